led_pattern_sequencer: RTL

//   Initiator side of the pattern begin/over handshake. Drives one-hot stBegin to N
//   LED-pattern state modules in turn, waits for the active module's stOver, then

---
 rtl/led_seq_pkg.sv | 16 +
 rtl/led_seq_if.sv | 30 +++
 rtl/led_seq_watchdog.sv | 46 ++++
 rtl/led_pattern_sequencer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared types and defaults for the LED pattern sequencer slice.
//   seq_state_t : sequencer FSM states (IDLE, RUN, GAP)
//   LED_W_DEF   : default LED bar width
//   NUM_ST_DEF  : default number of sequenced pattern state modules
package led_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } seq_state_t;

  localparam int unsigned LED_W_DEF  = 18;
  localparam int unsigned NUM_ST_DEF = 6;

endpackage : led_seq_pkg

// File: rtl/led_seq_if.sv
// led_seq_if: begin/over handshake bundle between the sequencer and the
// pattern state modules.
//   st_begin : one-hot begin, sequencer -> modules
//   st_over  : per-module done flag, modules -> sequencer
//   st_out   : flattened LED words, module i at [i*LED_W +: LED_W]
// Modports: master (sequencer side), slave (pattern module side).
interface led_seq_if
  import led_seq_pkg::*;
#(
  parameter int unsigned NUM_ST = NUM_ST_DEF,
  parameter int unsigned LED_W  = LED_W_DEF
);

  logic [NUM_ST-1:0]       st_begin;
  logic [NUM_ST-1:0]       st_over;
  logic [NUM_ST*LED_W-1:0] st_out;

  modport master (
    output st_begin,
    input  st_over,
    input  st_out
  );

  modport slave (
    input  st_begin,
    output st_over,
    output st_out
  );

endinterface : led_seq_if

// File: rtl/led_seq_watchdog.sv
// led_seq_watchdog: RUN-state cycle counter with expiry and sticky error flag.
//   clk, sync_rs   : clock, synchronous active-high reset
//   i_run          : sequencer is in RUN this cycle
//   i_take         : an expiry this cycle is acted on (run enable high)
//   o_expire_c     : combinational, high on the TIMEOUT-th consecutive RUN cycle
//   o_timeout_err  : registered sticky flag, cleared only by sync_rs
module led_seq_watchdog
  import led_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic clk,
  input  logic sync_rs,
  input  logic i_run,
  input  logic i_take,
  output logic o_expire_c,
  output logic o_timeout_err
);

  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [WD_W-1:0] r_cnt;
  logic            r_timeout_err;

  // Counter sits at zero outside RUN, so every RUN entry starts a fresh count.
  assign o_expire_c = i_run && (r_cnt == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (sync_rs) begin
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (!i_run || o_expire_c) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + WD_W'(1);
      end
      if (o_expire_c && i_take) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign o_timeout_err = r_timeout_err;

endmodule : led_seq_watchdog

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: initiator of the pattern begin/over handshake.
// Steps a one-hot st_begin through NUM_ST pattern modules, waits for the
// active module's st_over, idles GAP_CYC cycles, then moves to the next
// module. The active module's LED word is registered onto the LED bar.
//   clk, sync_rs : clock, synchronous active-high reset
//   enabler      : global run enable (low forces IDLE, index held)
//   seq_bus      : led_seq_if.master (st_begin out, st_over/st_out in)
//   out          : registered LED bar
//   cur_st       : index of the active/pending module
//   cycle_done   : one-cycle pulse when the index wraps to 0
//   timeout_err  : sticky watchdog flag
// Optional feature macro: LEDSEQ_WATCHDOG_EN (RUN-state watchdog; when
// undefined RUN waits indefinitely and timeout_err is tied low).
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned NUM_ST  = NUM_ST_DEF,
  parameter int unsigned LED_W   = LED_W_DEF,
  parameter int unsigned GAP_CYC = 1,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                      clk,
  input  logic                      sync_rs,
  input  logic                      enabler,
  led_seq_if.master                 seq_bus,
  output logic [LED_W-1:0]          out,
  output logic [$clog2(NUM_ST)-1:0] cur_st,
  output logic                      cycle_done,
  output logic                      timeout_err
);

  localparam int unsigned CUR_W = $clog2(NUM_ST);
  localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_RUN  = 2'(RUN);
  localparam logic [1:0] S_GAP  = 2'(GAP);

  logic [1:0]        r_state;
  logic [CUR_W-1:0]  r_cur_st;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [NUM_ST-1:0] r_st_begin;
  logic [LED_W-1:0]  r_out;
  logic              r_cycle_done;

  logic [1:0]        w_state_nxt;
  logic [CUR_W-1:0]  w_cur_nxt;
  logic [GAP_W-1:0]  w_gap_nxt;
  logic [NUM_ST-1:0] w_begin_nxt;
  logic [LED_W-1:0]  w_out_nxt;
  logic              w_wrap_c;
  logic              w_over_c;
  logic              w_expire_c;

`ifdef LEDSEQ_WATCHDOG_EN
  // Expiry acts as the active module's st_over.
  led_seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk           (clk),
    .sync_rs       (sync_rs),
    .i_run         (r_state == S_RUN),
    .i_take        (enabler),
    .o_expire_c    (w_expire_c),
    .o_timeout_err (timeout_err)
  );
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = 32'(TIMEOUT);
  assign w_expire_c       = 1'b0;
  assign timeout_err      = 1'b0;
`endif

  // Only the active module's st_over is looked at.
  assign w_over_c = seq_bus.st_over[r_cur_st] | w_expire_c;

  // Next state, index, gap count and next values of the registered outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur_st;
    w_gap_nxt   = r_gap_cnt;
    w_wrap_c    = 1'b0;
    w_begin_nxt = '0;
    w_out_nxt   = '0;

    case (r_state)
      S_IDLE: begin
        if (enabler) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!enabler) begin
          w_state_nxt = S_IDLE;
        end else if (w_over_c) begin
          w_state_nxt = S_GAP;
          w_gap_nxt   = '0;
        end
      end
      S_GAP: begin
        if (!enabler) begin
          w_state_nxt = S_IDLE;
          w_gap_nxt   = '0;
        end else if (r_gap_cnt == GAP_W'(GAP_CYC - 1)) begin
          w_state_nxt = S_RUN;
          w_gap_nxt   = '0;
          if (r_cur_st == CUR_W'(NUM_ST - 1)) begin
            w_cur_nxt = '0;
            w_wrap_c  = 1'b1;
          end else begin
            w_cur_nxt = r_cur_st + CUR_W'(1);
          end
        end else begin
          w_gap_nxt = r_gap_cnt + GAP_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gap_nxt   = '0;
      end
    endcase

    // Registered outputs follow the upcoming state: begin is decoded from the
    // next index, the LED word is sampled now and appears next cycle.
    if (w_state_nxt == S_RUN) begin
      w_begin_nxt[w_cur_nxt] = 1'b1;
      for (int unsigned i = 0; i < NUM_ST; i++) begin
        if (w_cur_nxt == CUR_W'(i)) begin
          w_out_nxt = seq_bus.st_out[i*LED_W +: LED_W];
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (sync_rs) begin
      r_state      <= S_IDLE;
      r_cur_st     <= '0;
      r_gap_cnt    <= '0;
      r_st_begin   <= '0;
      r_out        <= '0;
      r_cycle_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cur_st     <= w_cur_nxt;
      r_gap_cnt    <= w_gap_nxt;
      r_st_begin   <= w_begin_nxt;
      r_out        <= w_out_nxt;
      r_cycle_done <= w_wrap_c;
    end
  end

  assign seq_bus.st_begin = r_st_begin;
  assign out              = r_out;
  assign cur_st           = r_cur_st;
  assign cycle_done       = r_cycle_done;

endmodule : led_pattern_sequencer
